writeback_queue: RTL
====================

Name: writeback_queue

Overview:
- Collects results from up to SRC_PORTS functional units and buffers them in a circular queue.
- Drains up to WRITE_PORTS entries per cycle, oldest first, onto the write ports of the physical register file.
- Sits between execute/writeback and the register file and generates that file's wr_* port set.
- Has no backpressure from the register file: every presented write is consumed.

Parameters:
- DATA_WIDTH, 64, width of a data result.
- STATE_WIDTH, 4, width of a register state/tag field.
- PHYS_COUNT, 64, number of physical registers.
- ADDR_WIDTH, $clog2(PHYS_COUNT), physical register address width.
- SRC_PORTS, 4, number of functional-unit result inputs.
- WRITE_PORTS, 2, number of register file write ports driven.
- DEPTH, 8, queue entries; power of two, DEPTH >= SRC_PORTS.

Ports:
- clk  input  1  clock.
- async_rst  input  1  asynchronous active-high reset.
- clk_en  input  1  global clock enable; when low, all state holds.
- src_data_en  input  [SRC_PORTS]  source i carries a data write.
- src_state_en  input  [SRC_PORTS]  source i carries a state write.
- src_addr  input  ADDR_WIDTH x [SRC_PORTS]  destination physical register.
- src_data  input  DATA_WIDTH x [SRC_PORTS]  result data.
- src_state  input  STATE_WIDTH x [SRC_PORTS]  state value.
- src_ready  output  1  queue can accept all SRC_PORTS sources this cycle.
- wr_data_en  output  [WRITE_PORTS]  data write enable to the register file.
- wr_state_en  output  [WRITE_PORTS]  state write enable to the register file.
- wr_addr  output  ADDR_WIDTH x [WRITE_PORTS]  write address.
- wr_data  output  DATA_WIDTH x [WRITE_PORTS]  write data.
- wr_state  output  STATE_WIDTH x [WRITE_PORTS]  write state.
- count  output  $clog2(DEPTH)+1  occupied entries.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset (async, immediate): head, tail and count go to 0. All wr_* outputs go to 0. overflow goes to 0. src_ready goes to 1. Queued entries are discarded, including mid-drain.
- Entry format: {data_flag, state_flag, addr, data, state}.
- A source is valid when src_data_en[i] | src_state_en[i]. A source with neither bit set is ignored.
- src_ready = (DEPTH - count) >= SRC_PORTS. It is computed from registered count only and is all-or-nothing.
- Push, on a clk_en edge with src_ready=1:
  - All valid sources are written at tail, packed contiguously in ascending source index (lowest index = oldest).
  - tail advances by the number of valid sources, modulo DEPTH.
- Overflow: any valid source on a clk_en edge with src_ready=0 is dropped and sets overflow=1. overflow stays set until reset.
- Pop, on each clk_en edge:
  - n = min(count, WRITE_PORTS), with count taken before this edge's push.
  - Entries head..head+n-1 are loaded into the output registers, with port k holding the k-th oldest.
  - wr_data_en[k] = data_flag and wr_state_en[k] = state_flag for k < n. Both enables are 0 for k >= n.
  - head advances by n, modulo DEPTH.
- No bypass: an entry pushed at edge N is first poppable at edge N+1 and visible on wr_* after edge N+1. Minimum latency is 2 cycles from source presentation.
- count_next = count + pushes - pops. Simultaneous push and pop in the same edge is legal, including at the wrap-around point.
- Same address within one cycle: the older entry goes on the lower port and the younger on the higher port. The register file gives the higher port priority, so the younger write wins. Entries for the same address are never reordered.
- Both data_flag and state_flag set: both enables are asserted and the register file gives data priority. Splitting such entries is not the job of this block.
- clk_en=0: no push, no pop, and all registers hold. wr_* outputs hold their last values, which the register file ignores under the same clk_en.
- Empty queue: all wr enables are 0 after the next clk_en edge. wr_addr, wr_data and wr_state keep their previous values (don't-care).

Test Plan:
- Reset then idle: assert async_rst mid-cycle -> wr_data_en=0, wr_state_en=0, count=0, src_ready=1, overflow=0 immediately, without waiting for a clock edge.
- Single write: source 2 presents data_en=1, addr=5, data=0xABCD at edge 0 -> count=1 after edge 0. After edge 1: wr_data_en=2'b01, wr_addr[0]=5, wr_data[0]=0xABCD, count=0.
- Burst drain: all 4 sources valid at one edge (addr 1..4) -> over the next two edges, ports show {1,2} then {3,4}, in order.
- Full and overflow with DEPTH=8: push 4 on each of edges 0 and 1 -> count peaks at 6 after edge 1 (4 pushed at edge 0, 2 popped at edge 1). src_ready=0 while count>4. A valid source presented while src_ready=0 -> overflow=1 and stays 1; the dropped entry never appears on wr_*.
- Wrap-around plus simultaneous push/pop: steady 2-per-cycle push for 20 cycles -> count stable at 2. Entries emerge in exact push order across the pointer wrap.
- Ordering and clk_en: two entries to addr 7 (state 3 then state 9) -> same pop cycle, with port 0 = 3 and port 1 = 9. Holding clk_en=0 for 3 cycles freezes count and wr_* outputs.

Source files
------------

// File: rtl/writeback_queue.sv
// Circular writeback queue: packs valid functional-unit results at the tail and
// drains up to WRITE_PORTS entries per cycle, oldest first, onto register file write ports.
module writeback_queue #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned STATE_WIDTH = 4,
   parameter int unsigned PHYS_COUNT  = 64,
   parameter int unsigned ADDR_WIDTH  = $clog2(PHYS_COUNT),
   parameter int unsigned SRC_PORTS   = 4,
   parameter int unsigned WRITE_PORTS = 2,
   parameter int unsigned DEPTH       = 8
) (
   input  logic                                   clk,
   input  logic                                   async_rst,
   input  logic                                   clk_en,
   input  logic [SRC_PORTS-1:0]                   src_data_en,
   input  logic [SRC_PORTS-1:0]                   src_state_en,
   input  logic [SRC_PORTS-1:0][ADDR_WIDTH-1:0]   src_addr,
   input  logic [SRC_PORTS-1:0][DATA_WIDTH-1:0]   src_data,
   input  logic [SRC_PORTS-1:0][STATE_WIDTH-1:0]  src_state,
   output logic                                   src_ready,
   output logic [WRITE_PORTS-1:0]                 wr_data_en,
   output logic [WRITE_PORTS-1:0]                 wr_state_en,
   output logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wr_addr,
   output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
   output logic [WRITE_PORTS-1:0][STATE_WIDTH-1:0] wr_state,
   output logic [$clog2(DEPTH):0]                 count,
   output logic                                   overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic                   data_flag;
      logic                   state_flag;
      logic [ADDR_WIDTH-1:0]  addr;
      logic [DATA_WIDTH-1:0]  data;
      logic [STATE_WIDTH-1:0] state;
   } entry_t;

   entry_t                      mem [DEPTH];
   logic [PW-1:0]               head;
   logic [PW-1:0]               tail;
   logic [SRC_PORTS-1:0]        src_valid;
   logic [SRC_PORTS-1:0][PW-1:0] slot;
   logic [CW-1:0]               push_cnt;
   logic [CW-1:0]               push_eff;
   logic [CW-1:0]               pop_cnt;
   logic                        do_push;
   logic                        drop;

   assign src_valid = src_data_en | src_state_en;
   assign src_ready = (count <= CW'(DEPTH - SRC_PORTS));
   assign do_push   = clk_en & src_ready;
   assign drop      = clk_en & ~src_ready & (|src_valid);
   assign push_eff  = do_push ? push_cnt : '0;

   // Valid sources are packed contiguously: each takes the slot after all lower-index valid sources.
   always_comb begin
      push_cnt = '0;
      slot     = '0;
      for (int unsigned i = 0; i < SRC_PORTS; i++) begin
         slot[i] = tail + PW'(push_cnt);
         if (src_valid[i])
            push_cnt = push_cnt + 1'b1;
      end
   end

   always_comb begin
      if (32'(count) < WRITE_PORTS)
         pop_cnt = count;
      else
         pop_cnt = CW'(WRITE_PORTS);
   end

   // Storage needs no reset: occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) begin
         for (int unsigned i = 0; i < SRC_PORTS; i++) begin
            if (src_valid[i])
               mem[slot[i]] <= '{data_flag:  src_data_en[i],
                                 state_flag: src_state_en[i],
                                 addr:       src_addr[i],
                                 data:       src_data[i],
                                 state:      src_state[i]};
         end
      end
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         wr_data_en  <= '0;
         wr_state_en <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
         wr_state    <= '0;
      end else if (clk_en) begin
         for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
            if (32'(pop_cnt) > k) begin
               wr_data_en[k]  <= mem[head + PW'(k)].data_flag;
               wr_state_en[k] <= mem[head + PW'(k)].state_flag;
               wr_addr[k]     <= mem[head + PW'(k)].addr;
               wr_data[k]     <= mem[head + PW'(k)].data;
               wr_state[k]    <= mem[head + PW'(k)].state;
            end else begin
               wr_data_en[k]  <= 1'b0;
               wr_state_en[k] <= 1'b0;
            end
         end
         head  <= head + PW'(pop_cnt);
         tail  <= tail + PW'(push_eff);
         count <= count + push_eff - pop_cnt;
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule
